// File: rtl/cic_comb_decimator.sv
// CIC decimator back end: keeps every R-th integrator sample, then runs N
// pipelined comb stages (differential delay M) and truncates to OW bits.
module cic_comb_decimator #(
  parameter int IW = 10,
  parameter int OW = 10,
  parameter int R  = 8,
  parameter int N  = 3,
  parameter int M  = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [IW-1:0] i_data,
  output logic [OW-1:0] o_data,
  output logic          o_ready
);

  if (OW < 1 || OW > IW) begin : g_bad_ow
    $error("cic_comb_decimator: OW must be in 1..IW");
  end
  if (R < 1) begin : g_bad_r
    $error("cic_comb_decimator: R must be >= 1");
  end
  if (N < 1 || N > 8) begin : g_bad_n
    $error("cic_comb_decimator: N must be in 1..8");
  end
  if (M < 1 || M > 2) begin : g_bad_m
    $error("cic_comb_decimator: M must be in 1..2");
  end

  localparam int CW = (R > 1) ? $clog2(R) : 1;

  logic [CW-1:0] cnt;
  // Index 0 is the capture register; index k is the result of comb stage k.
  logic [IW-1:0] stage_data  [0:N];
  logic          stage_valid [0:N];
  // dly[k][0] is the most recent input to stage k, dly[k][M-1] the oldest.
  logic [IW-1:0] dly [1:N][0:M-1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt     <= '0;
      o_data  <= '0;
      o_ready <= 1'b0;
      for (int unsigned k = 0; k <= N; k++) begin
        stage_data[k]  <= '0;
        stage_valid[k] <= 1'b0;
      end
      for (int unsigned k = 1; k <= N; k++) begin
        for (int unsigned m = 0; m < M; m++) begin
          dly[k][m] <= '0;
        end
      end
    end else begin
      stage_valid[0] <= 1'b0;
      if (i_ce) begin
        if (cnt == CW'(R - 1)) begin
          cnt            <= '0;
          stage_data[0]  <= i_data;
          stage_valid[0] <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // Modular IW-bit subtraction: wrap-around cancels integrator overflow.
      for (int unsigned k = 1; k <= N; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        if (stage_valid[k-1]) begin
          stage_data[k] <= stage_data[k-1] - dly[k][M-1];
          dly[k][0]     <= stage_data[k-1];
          for (int unsigned m = 1; m < M; m++) begin
            dly[k][m] <= dly[k][m-1];
          end
        end
      end

      o_ready <= stage_valid[N];
      if (stage_valid[N]) begin
        o_data <= stage_data[N][IW-1 -: OW];
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Bench for cic_comb_decimator: directed small-config cases plus random
// stimulus on a wider config compared against a binomial-sum CIC model.
module tb_cic_comb_decimator;

  localparam int A_IW = 10, A_OW = 10, A_R = 1, A_N = 1, A_M = 1;
  localparam int B_IW = 12, B_OW = 8,  B_R = 3, B_N = 3, B_M = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_ce = 1'b0, b_ce = 1'b0;
  logic [A_IW-1:0] a_data_in = '0;
  logic [B_IW-1:0] b_data_in = '0;
  logic [A_OW-1:0] a_data;
  logic [B_OW-1:0] b_data;
  logic a_ready, b_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_comb_decimator #(.IW(A_IW), .OW(A_OW), .R(A_R), .N(A_N), .M(A_M)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_ce(a_ce), .i_data(a_data_in),
    .o_data(a_data), .o_ready(a_ready)
  );

  cic_comb_decimator #(.IW(B_IW), .OW(B_OW), .R(B_R), .N(B_N), .M(B_M)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_ce(b_ce), .i_data(b_data_in),
    .o_data(b_data), .o_ready(b_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int              at;
    logic [B_OW-1:0] v;
  } pend_t;

  pend_t           pend[$];
  logic [B_IW-1:0] hist[$];
  int              ce_cnt;
  int              cyc;
  logic [B_OW-1:0] last_b;
  logic [A_OW-1:0] last_a;
  logic            exp_rdy;
  logic [A_IW-1:0] a_in  [0:4];
  logic [A_OW-1:0] a_exp [0:4];
  int              a_n;

  initial begin
    #1;
    chk("reset_a_ready", a_ready, 1'b0);
    chk("reset_a_data", a_data, 10'd0);
    chk("reset_b_ready", b_ready, 1'b0);
    chk("reset_b_data", b_data, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed: R=1,N=1 difference sequences, including modular wrap.
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        a_n = 3;
        a_in[0] = 10'd5;  a_in[1] = 10'd7; a_in[2] = 10'd12;
        a_exp[0] = 10'd5; a_exp[1] = 10'd2; a_exp[2] = 10'd5;
      end else begin
        a_n = 2;
        a_in[0] = 10'd500;  a_in[1] = 10'(-500);
        a_exp[0] = 10'd500; a_exp[1] = 10'd24;
      end
      last_a = '0;
      for (int i = 0; i < a_n + A_N + 3; i++) begin
        @(negedge clk);
        exp_rdy = (i >= A_N + 2) && (i - (A_N + 2) < a_n);
        if (exp_rdy) last_a = a_exp[i - (A_N + 2)];
        chk("a_ready", a_ready, exp_rdy);
        chk("a_data", a_data, last_a);
        a_ce = (i < a_n);
        a_data_in = (i < a_n) ? a_in[i] : '0;
      end
      rst = 1'b1;
      #1;
      chk("a_reset_data", a_data, 10'd0);
      @(negedge clk);
      rst = 1'b0;
    end

    // Random: R=3,N=3,M=2,IW=12,OW=8 against the binomial comb model.
    cyc = 0; ce_cnt = 0; last_b = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      cyc++;
      exp_rdy = 1'b0;
      if (pend.size() > 0 && pend[0].at == cyc) begin
        exp_rdy = 1'b1;
        last_b  = pend[0].v;
        void'(pend.pop_front());
      end
      chk("b_ready", b_ready, exp_rdy);
      chk("b_data", b_data, last_b);

      if (c == 300) begin
        b_ce = 1'b0;
        rst  = 1'b1;
        #1;
        chk("b_midreset_ready", b_ready, 1'b0);
        chk("b_midreset_data", b_data, 8'd0);
        chk("b_midreset_inflight", pend.size() > 0, 1'b1);
        pend.delete(); hist.delete(); ce_cnt = 0; last_b = '0;
        @(negedge clk);
        cyc++;
        chk("b_held_ready", b_ready, 1'b0);
        rst = 1'b0;
      end

      b_ce = ((c >= 295 && c < 300) || $urandom_range(9) < 7) ? 1'b1 : 1'b0;
      b_data_in = B_IW'($urandom);
      if (b_ce) begin
        ce_cnt++;
        if (ce_cnt % B_R == 0) begin
          int s, coef, j, idx;
          logic [B_IW-1:0] y;
          hist.push_back(b_data_in);
          j = hist.size() - 1;
          s = 0;
          coef = 1;
          for (int i = 0; i <= B_N; i++) begin
            idx = j - i * B_M;
            if (idx >= 0) s += ((i % 2) ? -coef : coef) * int'(hist[idx]);
            coef = coef * (B_N - i) / (i + 1);
          end
          y = s[B_IW-1:0];
          pend.push_back('{at: cyc + B_N + 2, v: y[B_IW-1 -: B_OW]});
        end
      end
    end

    b_ce = 1'b0;
    for (int c = 0; c < B_N + 4; c++) begin
      @(negedge clk);
      cyc++;
      exp_rdy = 1'b0;
      if (pend.size() > 0 && pend[0].at == cyc) begin
        exp_rdy = 1'b1;
        last_b  = pend[0].v;
        void'(pend.pop_front());
      end
      chk("b_drain_ready", b_ready, exp_rdy);
      chk("b_drain_data", b_data, last_b);
    end
    chk("b_all_drained", pend.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
